// File: rtl/mute_tile_sched_if.sv
// Handshake bundle between the tile scheduler, its frame controller and mute_cpu.
// i_* signals flow into the scheduler; o_* signals are driven by it.
interface mute_tile_sched_if #(
    parameter int CW = 17
);
    logic          i_start;
    logic [CW-1:0] i_img_rows;
    logic [CW-1:0] i_img_cols;
    logic          i_end_cpu;
    logic [CW-1:0] i_next_row;
    logic [CW-1:0] i_next_column;
    logic [CW-1:0] o_row;
    logic [CW-1:0] o_column;
    logic          o_cpu_rst;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_err;
    logic [15:0]   o_tile_count;

    modport master (
        output i_start, i_img_rows, i_img_cols, i_end_cpu, i_next_row, i_next_column,
        input  o_row, o_column, o_cpu_rst, o_busy, o_frame_done, o_err, o_tile_count
    );

    modport slave (
        input  i_start, i_img_rows, i_img_cols, i_end_cpu, i_next_row, i_next_column,
        output o_row, o_column, o_cpu_rst, o_busy, o_frame_done, o_err, o_tile_count
    );
endinterface

// File: rtl/mute_tile_sched.sv
// Raster-order tile scheduler for mute_cpu: launches one tile per cpu reset pulse,
// follows the cpu-reported next origin, and flags timeouts / non-advancing origins.
module mute_tile_sched #(
    parameter int RST_CYC = 4,
    parameter int TIMEOUT = 65535,
    parameter int CW      = 17
) (
    input logic               clk,
    input logic               rst_n,
    mute_tile_sched_if.slave  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]    r_state;
    logic [CW-1:0] r_rows;
    logic [CW-1:0] r_cols;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_nr;
    logic [CW-1:0] r_nc;
    logic [31:0]   r_cnt;
    logic          r_cpu_rst;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_err;
    logic [15:0]   r_tile_count;

    logic          w_row_end;
    logic [CW-1:0] w_new_col;
    logic          w_progress;

    // Candidate origin for the next tile; columns past the frame edge wrap to 0.
    assign w_row_end  = (r_nc >= r_cols);
    assign w_new_col  = w_row_end ? '0 : r_nc;
    assign w_progress = (r_nr > r_row) || ((r_nr == r_row) && (w_new_col > r_col));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rows       <= '0;
            r_cols       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_nr         <= '0;
            r_nc         <= '0;
            r_cnt        <= '0;
            r_cpu_rst    <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_tile_count <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cpu_rst <= 1'b1;
                    if (bus.i_start) begin
                        r_rows       <= bus.i_img_rows;
                        r_cols       <= bus.i_img_cols;
                        r_row        <= '0;
                        r_col        <= '0;
                        r_tile_count <= '0;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cpu_rst <= 1'b1;
                    // An empty frame finishes cleanly without ever releasing the cpu.
                    if ((r_rows == '0) || (r_cols == '0)) begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (r_cnt == 32'(RST_CYC - 1)) begin
                        r_cnt     <= '0;
                        r_cpu_rst <= 1'b0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_WAIT: begin
                    if (bus.i_end_cpu) begin
                        r_nr <= bus.i_next_row;
                        r_nc <= bus.i_next_column;
                        if (r_tile_count != 16'hFFFF) begin
                            r_tile_count <= r_tile_count + 16'd1;
                        end
                        r_state <= S_ADVANCE;
                    end else if (r_cnt == 32'(TIMEOUT - 1)) begin
                        r_err        <= 1'b1;
                        r_cpu_rst    <= 1'b1;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_ADVANCE: begin
                    r_cpu_rst <= 1'b1;
                    if (r_nr >= r_rows) begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else if (!w_progress) begin
                        // A cpu that does not move forward would loop forever; abort the frame.
                        r_err        <= 1'b1;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_row   <= r_nr;
                        r_col   <= w_new_col;
                        r_cnt   <= '0;
                        r_state <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    r_cpu_rst <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_cpu_rst <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_row        = r_row;
    assign bus.o_column     = r_col;
    assign bus.o_cpu_rst    = r_cpu_rst;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_frame_done;
    assign bus.o_err        = r_err;
    assign bus.o_tile_count = r_tile_count;
endmodule

// File: tb/tb_mute_tile_sched.sv
// Bench for mute_tile_sched: a behavioural mute_cpu model plus a raster-order
// reference that predicts every launched origin, tile count and error outcome.
module tb_mute_tile_sched;
    localparam int RST_CYC = 4;
    localparam int TIMEOUT = 100;
    localparam int CW      = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mute_tile_sched_if #(.CW(CW)) bus ();

    mute_tile_sched #(.RST_CYC(RST_CYC), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // mode 0: step right by sc, next row by sr on overflow; 1: never finishes;
    // 2: always returns origin 0,0; 3: same row, column at the frame edge; 4: jittery steps.
    function automatic void cpu_resp(input int mode, input int r, input int c, input int sr,
                                     input int sc, input int cols, output int nr, output int nc);
        nr = r;
        nc = c;
        case (mode)
            0: begin nc = c + sc; if (nc >= cols) nr = r + sr; end
            2: begin nr = 0; nc = 0; end
            3: begin nr = r; nc = cols; end
            4: begin
                nc = c + ((r * 7 + c * 13 + 5) % 9) - 2;
                if (nc < 0) nc = 0;
                if (nc >= cols) nr = r + sr;
            end
            default: ;
        endcase
    endfunction

    int exp_org[$];
    int got_org[$];

    function automatic void ref_frame(input int mode, input int rows, input int cols, input int sr,
                                      input int sc, output int tiles, output int err);
        int r, c, nr, nc, wc;
        exp_org.delete();
        tiles = 0;
        err = 0;
        if (rows == 0 || cols == 0) return;
        if (mode == 1) begin exp_org.push_back(0); err = 1; return; end
        r = 0;
        c = 0;
        for (int i = 0; i < 5000; i++) begin
            exp_org.push_back(r * 65536 + c);
            tiles++;
            cpu_resp(mode, r, c, sr, sc, cols, nr, nc);
            if (nr >= rows) return;
            wc = (nc >= cols) ? 0 : nc;
            if (nr * 65536 + wc <= r * 65536 + c) begin err = 1; return; end
            r = nr;
            c = wc;
        end
    endfunction

    // ---------------- mute_cpu model ----------------
    int cpu_mode = 0, cpu_sr = 30, cpu_sc = 30, f_cols = 1;
    int cpu_mind = 0, cpu_maxd = 3;
    int cpu_wait = 0;
    bit cpu_running = 0;

    task automatic cpu_deliver();
        int nr, nc;
        cpu_resp(cpu_mode, int'(bus.o_row), int'(bus.o_column), cpu_sr, cpu_sc, f_cols, nr, nc);
        bus.i_next_row    = CW'(nr);
        bus.i_next_column = CW'(nc);
        bus.i_end_cpu     = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n || bus.o_cpu_rst) begin
            bus.i_end_cpu = 1'b0;
            cpu_running = 0;
        end else if (!cpu_running) begin
            cpu_running = 1;
            cpu_wait = int'($urandom_range(cpu_maxd, cpu_mind));
            if (cpu_wait == 0 && cpu_mode != 1) cpu_deliver();
        end else if (!bus.i_end_cpu && cpu_mode != 1) begin
            if (cpu_wait > 0) cpu_wait--;
            if (cpu_wait == 0) cpu_deliver();
        end
    end

    // ---------------- output monitor ----------------
    int  fd_cnt = 0, hi_len = 0, low_len = 0, tc_viol = 0;
    bit  prev_rst = 1, prev_busy = 0, rose = 0, turn_chk = 0;
    int  prev_tc = 0;

    always @(negedge clk) begin
        if (bus.o_frame_done) fd_cnt++;
        if (prev_busy && bus.o_busy && int'(bus.o_tile_count) < prev_tc) tc_viol++;
        if (bus.o_cpu_rst) begin
            if (!prev_rst) begin
                if (turn_chk) check("turnaround", low_len, 2);
                hi_len = 0;
                rose = bus.o_busy;
            end
            hi_len++;
            low_len = 0;
        end else begin
            if (prev_rst) begin
                if (rose) check("rst_pulse_len", hi_len, RST_CYC);
                got_org.push_back(int'(bus.o_row) * 65536 + int'(bus.o_column));
            end
            low_len++;
        end
        if (!bus.o_busy) rose = 0;
        prev_rst  = bus.o_cpu_rst;
        prev_busy = bus.o_busy;
        prev_tc   = int'(bus.o_tile_count);
    end

    task automatic launch(input int rows, input int cols, input int mode, input int sr, input int sc);
        cpu_mode = mode; cpu_sr = sr; cpu_sc = sc; f_cols = cols;
        @(negedge clk);
        bus.i_img_rows = CW'(rows);
        bus.i_img_cols = CW'(cols);
        bus.i_start = 1'b1;
        got_org.delete();
        fd_cnt = 0;
        tc_viol = 0;
        @(negedge clk);
    endtask

    task automatic run_frame(input int rows, input int cols, input int mode, input int sr,
                             input int sc, input bit hold, input int exp_tiles, input int exp_err);
        int mt, me, bad;
        bit seen;
        ref_frame(mode, rows, cols, sr, sc, mt, me);
        launch(rows, cols, mode, sr, sc);
        if (!hold) bus.i_start = 1'b0;
        check("busy_after_start", bus.o_busy, 1);
        seen = 0;
        for (int n = 0; n < 20000; n++) begin
            if (bus.o_frame_done) begin seen = 1; break; end
            @(negedge clk);
        end
        bus.i_start = 1'b0;
        if (!seen) begin
            check("frame_done_timeout", 0, 1);
            return;
        end
        check("tile_count", bus.o_tile_count, exp_tiles);
        check("err", bus.o_err, exp_err);
        check("busy_at_done", bus.o_busy, 0);
        repeat (3) @(negedge clk);
        check("frame_done_pulses", fd_cnt, 1);
        check("tile_count_monotonic_viol", tc_viol, 0);
        bad = (got_org.size() != exp_org.size()) ? 1 : 0;
        if (bad == 0)
            foreach (exp_org[i]) if (got_org[i] != exp_org[i]) bad++;
        check("launch_origins_bad", bad, 0);
        $display("frame rows=%0d cols=%0d mode=%0d tiles=%0d err=%0d launches=%0d",
                 rows, cols, mode, bus.o_tile_count, bus.o_err, got_org.size());
    endtask

    typedef struct {
        int rows; int cols; int mode; int sr; int sc; int exp_tiles; int exp_err;
    } vec_t;
    vec_t vecs[11];

    initial begin
        int t, e, k_fall, n_fd, saved;
        bus.i_start = 1'b0;
        bus.i_img_rows = '0;
        bus.i_img_cols = '0;
        bus.i_end_cpu = 1'b0;
        bus.i_next_row = '0;
        bus.i_next_column = '0;

        vecs[0]  = '{210, 240, 0, 30, 30, 56, 0};
        vecs[1]  = '{30,  30,  0, 30, 30, 1,  0};
        vecs[2]  = '{60,  90,  0, 30, 30, 6,  0};
        vecs[3]  = '{100, 20,  0, 25, 30, 4,  0};
        vecs[4]  = '{210, 240, 2, 30, 30, 1,  1};
        vecs[5]  = '{50,  50,  3, 30, 30, 1,  1};
        vecs[6]  = '{0,   240, 0, 30, 30, 0,  0};
        vecs[7]  = '{210, 0,   0, 30, 30, 0,  0};
        vecs[8]  = '{210, 240, 1, 30, 30, 0,  1};
        vecs[9]  = '{1,   1,   0, 1,  1,  1,  0};
        vecs[10] = '{40,  40,  0, 10, 50, 4,  0};

        repeat (3) @(negedge clk);
        check("rst_row", bus.o_row, 0);
        check("rst_column", bus.o_column, 0);
        check("rst_cpu_rst", bus.o_cpu_rst, 1);
        check("rst_busy", bus.o_busy, 0);
        check("rst_frame_done", bus.o_frame_done, 0);
        check("rst_err", bus.o_err, 0);
        check("rst_tile_count", bus.o_tile_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i])
            run_frame(vecs[i].rows, vecs[i].cols, vecs[i].mode, vecs[i].sr, vecs[i].sc, 1'b0,
                      vecs[i].exp_tiles, vecs[i].exp_err);

        // start held high for the whole frame must not restart it
        run_frame(210, 240, 0, 30, 30, 1'b1, 56, 0);

        // launch latency and timeout distance
        launch(5, 5, 1, 1, 1);
        bus.i_start = 1'b0;
        check("to_busy_t1", bus.o_busy, 1);
        k_fall = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!bus.o_cpu_rst) begin k_fall = k; break; end
            @(negedge clk);
        end
        check("launch_fall_cycle", k_fall, RST_CYC + 1);
        n_fd = -1;
        for (int n = 0; n < 300; n++) begin
            if (bus.o_frame_done) begin n_fd = n; break; end
            @(negedge clk);
        end
        check("timeout_cycles", n_fd, TIMEOUT);
        check("timeout_err", bus.o_err, 1);
        check("timeout_tiles", bus.o_tile_count, 0);
        check("timeout_cpu_rst", bus.o_cpu_rst, 1);
        @(negedge clk);
        check("timeout_fd_one_cycle", bus.o_frame_done, 0);
        $display("timeout fall_cycle=%0d done_after=%0d", k_fall, n_fd);

        // zero width: done two cycles after start, cpu never released
        repeat (2) @(negedge clk);
        launch(20, 0, 0, 30, 30);
        bus.i_start = 1'b0;
        check("zero_fd_t1", bus.o_frame_done, 0);
        check("zero_cpu_rst_t1", bus.o_cpu_rst, 1);
        @(negedge clk);
        check("zero_fd_t2", bus.o_frame_done, 1);
        check("zero_cpu_rst_t2", bus.o_cpu_rst, 1);
        check("zero_err", bus.o_err, 0);
        check("zero_tiles", bus.o_tile_count, 0);
        $display("zero-dim frame_done=%0d tiles=%0d", bus.o_frame_done, bus.o_tile_count);
        repeat (3) @(negedge clk);

        // cpu that finishes in its first WAIT cycle: cpu_rst low for exactly 2 cycles
        cpu_maxd = 0;
        turn_chk = 1;
        run_frame(60, 90, 0, 30, 30, 1'b0, 6, 0);
        turn_chk = 0;

        // asynchronous reset during WAIT of tile 3
        cpu_mind = 5;
        cpu_maxd = 5;
        launch(210, 240, 0, 30, 30);
        bus.i_start = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (got_org.size() >= 3) break;
            @(negedge clk);
        end
        check("reached_tile3", (got_org.size() >= 3) ? 1 : 0, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_row", bus.o_row, 0);
        check("ar_column", bus.o_column, 0);
        check("ar_cpu_rst", bus.o_cpu_rst, 1);
        check("ar_busy", bus.o_busy, 0);
        check("ar_frame_done", bus.o_frame_done, 0);
        check("ar_err", bus.o_err, 0);
        check("ar_tile_count", bus.o_tile_count, 0);
        saved = fd_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("ar_no_frame_done", fd_cnt, saved);
        $display("async reset mid-frame tiles_launched=%0d", got_org.size());
        cpu_mind = 0;
        cpu_maxd = 3;
        run_frame(210, 240, 0, 30, 30, 1'b0, 56, 0);

        // randomized frames against the reference
        for (int i = 0; i < 12; i++) begin
            int rows, cols, mode, sr, sc;
            rows = int'($urandom_range(40, 1));
            cols = int'($urandom_range(40, 1));
            mode = ($urandom_range(1, 0) == 0) ? 0 : 4;
            sr   = int'($urandom_range(20, 4));
            sc   = int'($urandom_range(20, 4));
            cpu_maxd = int'($urandom_range(3, 0));
            ref_frame(mode, rows, cols, sr, sc, t, e);
            run_frame(rows, cols, mode, sr, sc, 1'b0, t, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mute_tile_sched.md
# mute_tile_sched

Frame-level tile scheduler that sits directly upstream of `mute_cpu` in the convolution-filtering manycore path. It walks an image in raster order and drives the `row`/`column` origin into `mute_cpu`. It restarts the cpu for each tile through the cpu's active-high reset, waits for `end_cpu`, and then takes the cpu-reported `next_row`/`next_column` as the next origin. It reports per-frame completion, a tile count, and protocol errors (timeout, non-advancing cpu).

## Interface
- `RST_CYC`, 4: cycles `cpu_rst` is held high per tile launch (≥1).
- `TIMEOUT`, 65535: max cycles waiting for `end_cpu` per tile.
- `CW`, 17: coordinate width; matches `mute_cpu` row/column ports.
- `clk` input 1: single clock, all logic rising-edge.
- `reset` input 1: asynchronous, active-low. Low clears all state immediately.
- `start` input 1: one-cycle request to begin a frame; sampled only in IDLE.
- `img_rows` input CW: frame height; latched on accepted `start`.
- `img_cols` input CW: frame width; latched on accepted `start`.
- `end_cpu` input 1: from `mute_cpu`; tile finished.
- `next_row` input CW: from `mute_cpu`; valid while `end_cpu`=1.
- `next_column` input CW: from `mute_cpu`; valid while `end_cpu`=1.
- `row` output CW: tile origin row to `mute_cpu`.
- `column` output CW: tile origin column to `mute_cpu`.
- `cpu_rst` output 1: active-high reset/launch into `mute_cpu`.
- `busy` output 1: high from accepted `start` until DONE is entered.
- `frame_done` output 1: one-cycle pulse on frame completion, both normal and error.
- `err` output 1: sticky error flag; cleared on next accepted `start`.
- `tile_count` output 16: tiles completed this frame; saturates at 16'hFFFF.

## Operation
- States: IDLE, LAUNCH, WAIT, ADVANCE, DONE.
- Reset values: state=IDLE, `row`=0, `column`=0, `cpu_rst`=1 (cpu held in reset), `busy`=0, `frame_done`=0, `err`=0, `tile_count`=0, internal counters=0.
- IDLE: `cpu_rst`=1.
  - On `start`=1: latch `img_rows`/`img_cols`, set `row`=0, `column`=0, `tile_count`=0, `err`=0, `busy`=1, go to LAUNCH.
  - If a latched dimension is 0: go directly to DONE with `err`=0 and `tile_count`=0.
- LAUNCH: `cpu_rst`=1 for exactly RST_CYC cycles, counted from LAUNCH entry, then go to WAIT. `row`/`column` are stable throughout.
- WAIT: `cpu_rst`=0, wait counter increments each cycle.
  - `end_cpu`=1: capture `next_row`/`next_column`, increment `tile_count` (saturating), go to ADVANCE.
  - Counter reaches TIMEOUT with no `end_cpu`: set `err`=1, go to DONE.
  - `end_cpu` already high on the first WAIT cycle counts as completion.
- ADVANCE: one cycle. Let (nr, nc) be the captured values. Checks are applied in this order:
  - If nr ≥ img_rows → DONE.
  - Else if nc ≥ img_cols → wrap: `row`=nr, `column`=0.
  - Else `row`=nr, `column`=nc.
  - Progress check: the new origin must be strictly later in raster order than the old one (row greater, or row equal and column greater). If it is not, set `err`=1 and go to DONE instead of launching, which prevents an infinite loop. Wrapped origins with nr equal to the old row fail this check.
  - If both checks pass, go to LAUNCH.
- DONE: `frame_done`=1 for one cycle, `busy`=0, `cpu_rst`=1, return to IDLE. `row`/`column` hold their last values.
- `start` outside IDLE is ignored.
- Reset low in any state aborts the frame immediately. No `frame_done` is issued.

## Timing
- `start` sampled at edge T → `busy`=1 and `cpu_rst`=1 from T+1. `cpu_rst` falls at T+1+RST_CYC.
- `end_cpu` sampled at edge E → ADVANCE during E+1. `cpu_rst` rises again at E+2 for the next tile, or `frame_done` is asserted during E+2.
- Per-tile overhead is RST_CYC+2 cycles beyond cpu runtime.
- Outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Normal frame: `img_rows`=210, `img_cols`=240, RST_CYC=4. Cpu model returns `next_column`=column+30, and at ≥240 returns `next_row`=row+30 with column wrapped.
  - Expect 7×8=56 tiles, `tile_count`=56, one `frame_done` pulse, `err`=0.
  - Each `cpu_rst` high pulse lasts exactly 4 cycles.
- Timeout: model never asserts `end_cpu`, TIMEOUT=100.
  - Expect `err`=1 and `frame_done` 100 cycles after `cpu_rst` falls, `tile_count`=0.
- Non-advancing cpu: model returns `next_row`=0, `next_column`=0 on the first tile.
  - Expect `tile_count`=1, `err`=1, `frame_done` pulse, no second launch.
- Zero dimension: `start` with `img_cols`=0.
  - Expect `frame_done` 2 cycles later, `tile_count`=0, `err`=0, `cpu_rst` never deasserted.
- Reset mid-frame: drive `reset` low during WAIT of tile 3.
  - Expect all outputs at reset values asynchronously, no `frame_done`.
  - A new `start` then runs a full frame correctly.
- `start` held high during a frame: no restart; `tile_count` continues monotonically.
